instruction_fetch: RTL and testbench



---
 rtl/cpu_pkg.sv | 24 ++
 rtl/instruction_fetch.sv | 155 +++++++++++++++
 tb/tb_instruction_fetch.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, reset PC, fetch FSM encoding
// and the opcodes the decoder/control uses to raise halt or redirect.
package cpu_pkg;

  // Datapath widths and reset program counter
  localparam int ADDR_W   = 8;
  localparam int INSTR_W  = 8;
  localparam int RESET_PC = 32'd0;

  // Fetch stage FSM encoding
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } fetch_state_t;

  // Opcodes that feed back into fetch: HALT drives halt, jumps drive redirect
  localparam logic [7:0] OP_HALT = 8'hFF;
  localparam logic [7:0] OP_JMP  = 8'hE0;
  localparam logic [7:0] OP_JZ   = 8'hE1;
  localparam logic [7:0] OP_JNZ  = 8'hE2;

endpackage

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: owns the program counter, reads the synchronous
// instruction memory (one-cycle latency) and presents each instruction to
// the decoder through an ir/ir_valid/ir_ready handshake. Redirects from
// execute reload the PC and flush whatever fetch is in progress.
module instruction_fetch #(
  parameter int                ADDR_W   = cpu_pkg::ADDR_W,
  parameter int                INSTR_W  = cpu_pkg::INSTR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(cpu_pkg::RESET_PC)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               halt,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_addr,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic               imem_rd,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [INSTR_W-1:0] ir,
  output logic [ADDR_W-1:0]  ir_pc,
  output logic               ir_valid,
  input  logic               ir_ready,
  output logic [ADDR_W-1:0]  pc,
  output logic               busy
);

  import cpu_pkg::fetch_state_t;
  import cpu_pkg::IDLE;
  import cpu_pkg::FETCH;
  import cpu_pkg::WAIT;
  import cpu_pkg::HOLD;

  fetch_state_t       state_r;
  fetch_state_t       next_state_s;
  logic               run_s;
  logic               transfer_s;
  logic [ADDR_W-1:0]  pc_r;
  logic [INSTR_W-1:0] ir_r;
  logic [ADDR_W-1:0]  ir_pc_r;
  logic               ir_valid_r;
  logic               imem_rd_s;
  logic               busy_s;
  logic               imem_rd_r;
  logic               busy_r;

  // PC increment wraps naturally at 2^ADDR_W; no overflow flag is kept
  function automatic logic [ADDR_W-1:0] pc_inc(input logic [ADDR_W-1:0] cur);
    return cur + {{(ADDR_W-1){1'b0}}, 1'b1};
  endfunction

  // halt behaves exactly like en=0; a transfer is the handshake completing
  assign run_s      = en & ~halt;
  assign transfer_s = ir_valid_r & ir_ready;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // FSM next-state logic; redirect overrides every state
  always_comb begin
    next_state_s = state_r;
    if (redirect) begin
      next_state_s = run_s ? FETCH : IDLE;
    end else begin
      case (state_r)
        IDLE:    next_state_s = run_s ? FETCH : IDLE;
        FETCH:   next_state_s = WAIT;
        WAIT:    next_state_s = HOLD;
        HOLD: begin
          if (transfer_s) begin
            next_state_s = run_s ? FETCH : IDLE;
          end else begin
            next_state_s = HOLD;
          end
        end
        default: next_state_s = IDLE;
      endcase
    end
  end

  // FSM output decode, computed for the state being entered so the
  // strobes can be registered and still line up with that state
  always_comb begin
    imem_rd_s = 1'b0;
    busy_s    = 1'b0;
    if (next_state_s == FETCH) begin
      imem_rd_s = 1'b1;
    end else begin
      imem_rd_s = 1'b0;
    end
    if (next_state_s != IDLE) begin
      busy_s = 1'b1;
    end else begin
      busy_s = 1'b0;
    end
  end

  // Registered control outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      imem_rd_r <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      imem_rd_r <= imem_rd_s;
      busy_r    <= busy_s;
    end
  end

  // PC and instruction register: capture in WAIT, release on transfer,
  // and on redirect drop any returning data without advancing the PC
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r       <= RESET_PC;
      ir_r       <= {INSTR_W{1'b0}};
      ir_pc_r    <= {ADDR_W{1'b0}};
      ir_valid_r <= 1'b0;
    end else if (redirect) begin
      pc_r       <= redirect_addr;
      ir_valid_r <= 1'b0;
    end else begin
      case (state_r)
        WAIT: begin
          ir_r       <= imem_data;
          ir_pc_r    <= pc_r;
          ir_valid_r <= 1'b1;
          pc_r       <= pc_inc(pc_r);
        end
        HOLD: begin
          if (transfer_s) begin
            ir_valid_r <= 1'b0;
          end else begin
            ir_valid_r <= ir_valid_r;
          end
        end
        default: begin
          ir_valid_r <= ir_valid_r;
        end
      endcase
    end
  end

  assign imem_addr = pc_r;
  assign imem_rd   = imem_rd_r;
  assign ir        = ir_r;
  assign ir_pc     = ir_pc_r;
  assign ir_valid  = ir_valid_r;
  assign pc        = pc_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: a vector table for the basic fetch,
// stall, idle and reset sequences, then hand-written redirect/halt/wrap cases.
module tb_instruction_fetch;

  logic       clk;
  logic       rst;
  logic       en;
  logic       halt;
  logic       redirect;
  logic [7:0] redirect_addr;
  logic [7:0] imem_addr;
  logic       imem_rd;
  logic [7:0] imem_data;
  logic [7:0] ir;
  logic [7:0] ir_pc;
  logic       ir_valid;
  logic       ir_ready;
  logic [7:0] pc;
  logic       busy;

  int total;
  int bad;
  int xfer_cnt;
  int cnt0;

  logic [7:0] mem [256];

  typedef struct {
    logic       rst;
    logic       en;
    logic       halt;
    logic       redir;
    logic [7:0] raddr;
    logic       rdy;
    logic       e_rd;
    logic       e_busy;
    logic       e_valid;
    logic [7:0] e_ir;
    logic [7:0] e_irpc;
    logic [7:0] e_pc;
  } vec_t;

  vec_t vecs[$];

  instruction_fetch dut (
    .clk(clk), .rst(rst), .en(en), .halt(halt),
    .redirect(redirect), .redirect_addr(redirect_addr),
    .imem_addr(imem_addr), .imem_rd(imem_rd), .imem_data(imem_data),
    .ir(ir), .ir_pc(ir_pc), .ir_valid(ir_valid), .ir_ready(ir_ready),
    .pc(pc), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous memory: data appears the cycle after the read strobe
  always @(posedge clk) begin
    if (imem_rd) imem_data <= mem[imem_addr];
  end

  // Count completed handshakes
  always @(posedge clk) begin
    if (!rst && ir_valid && ir_ready) xfer_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic e_rd, input logic e_busy,
                         input logic e_valid, input logic [7:0] e_ir,
                         input logic [7:0] e_irpc, input logic [7:0] e_pc);
    chk({tag, ".imem_rd"},   {31'd0, imem_rd},  {31'd0, e_rd});
    chk({tag, ".busy"},      {31'd0, busy},     {31'd0, e_busy});
    chk({tag, ".ir_valid"},  {31'd0, ir_valid}, {31'd0, e_valid});
    chk({tag, ".ir"},        {24'd0, ir},       {24'd0, e_ir});
    chk({tag, ".ir_pc"},     {24'd0, ir_pc},    {24'd0, e_irpc});
    chk({tag, ".pc"},        {24'd0, pc},       {24'd0, e_pc});
    chk({tag, ".imem_addr"}, {24'd0, imem_addr}, {24'd0, e_pc});
  endtask

  function automatic vec_t mk(input logic r, input logic e, input logic h, input logic rd_i,
                              input logic [7:0] ra, input logic rdy,
                              input logic xrd, input logic xb, input logic xv,
                              input logic [7:0] xir, input logic [7:0] xirpc, input logic [7:0] xpc);
    vec_t v;
    v.rst = r; v.en = e; v.halt = h; v.redir = rd_i; v.raddr = ra; v.rdy = rdy;
    v.e_rd = xrd; v.e_busy = xb; v.e_valid = xv;
    v.e_ir = xir; v.e_irpc = xirpc; v.e_pc = xpc;
    return v;
  endfunction

  initial begin
    total = 0; bad = 0; xfer_cnt = 0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h00] = 8'h10; mem[8'h01] = 8'h2D; mem[8'h02] = 8'h35;
    mem[8'h80] = 8'h77; mem[8'h81] = 8'hAA; mem[8'h40] = 8'h3C;
    mem[8'hFF] = 8'h99;
    imem_data = 8'h00;
    rst = 1'b1; en = 1'b0; halt = 1'b0; redirect = 1'b0;
    redirect_addr = 8'h00; ir_ready = 1'b0;

    //            rst en  hlt red raddr  rdy   rd  busy vld ir     irpc   pc
    vecs.push_back(mk(1, 0, 0, 0, 8'h00, 0,   0, 0, 0, 8'h00, 8'h00, 8'h00));
    // back-to-back fetch of 0x10, 0x2D, 0x35 with ready held high
    vecs.push_back(mk(0, 1, 0, 0, 8'h00, 1,   1, 1, 0, 8'h00, 8'h00, 8'h00));
    vecs.push_back(mk(0, 1, 0, 0, 8'h00, 1,   0, 1, 0, 8'h00, 8'h00, 8'h00));
    vecs.push_back(mk(0, 1, 0, 0, 8'h00, 1,   0, 1, 1, 8'h10, 8'h00, 8'h01));
    vecs.push_back(mk(0, 1, 0, 0, 8'h00, 1,   1, 1, 0, 8'h10, 8'h00, 8'h01));
    vecs.push_back(mk(0, 1, 0, 0, 8'h00, 1,   0, 1, 0, 8'h10, 8'h00, 8'h01));
    vecs.push_back(mk(0, 1, 0, 0, 8'h00, 1,   0, 1, 1, 8'h2D, 8'h01, 8'h02));
    vecs.push_back(mk(0, 1, 0, 0, 8'h00, 1,   1, 1, 0, 8'h2D, 8'h01, 8'h02));
    vecs.push_back(mk(0, 1, 0, 0, 8'h00, 1,   0, 1, 0, 8'h2D, 8'h01, 8'h02));
    vecs.push_back(mk(0, 1, 0, 0, 8'h00, 1,   0, 1, 1, 8'h35, 8'h02, 8'h03));
    // en drops: last transfer goes to IDLE, pc retained
    vecs.push_back(mk(0, 0, 0, 0, 8'h00, 1,   0, 0, 0, 8'h35, 8'h02, 8'h03));
    vecs.push_back(mk(0, 0, 0, 0, 8'h00, 1,   0, 0, 0, 8'h35, 8'h02, 8'h03));
    // redirect while stopped loads pc but stays IDLE; halt blocks start
    vecs.push_back(mk(0, 0, 0, 1, 8'h20, 0,   0, 0, 0, 8'h35, 8'h02, 8'h20));
    vecs.push_back(mk(0, 1, 1, 0, 8'h00, 0,   0, 0, 0, 8'h35, 8'h02, 8'h20));
    vecs.push_back(mk(1, 0, 0, 0, 8'h00, 0,   0, 0, 0, 8'h00, 8'h00, 8'h00));
    // decoder stalls 5 cycles in HOLD, then accepts
    vecs.push_back(mk(0, 1, 0, 0, 8'h00, 0,   1, 1, 0, 8'h00, 8'h00, 8'h00));
    vecs.push_back(mk(0, 1, 0, 0, 8'h00, 0,   0, 1, 0, 8'h00, 8'h00, 8'h00));
    vecs.push_back(mk(0, 1, 0, 0, 8'h00, 0,   0, 1, 1, 8'h10, 8'h00, 8'h01));
    for (int k = 0; k < 5; k++)
      vecs.push_back(mk(0, 1, 0, 0, 8'h00, 0, 0, 1, 1, 8'h10, 8'h00, 8'h01));
    vecs.push_back(mk(0, 1, 0, 0, 8'h00, 1,   1, 1, 0, 8'h10, 8'h00, 8'h01));
    vecs.push_back(mk(0, 1, 0, 0, 8'h00, 1,   0, 1, 0, 8'h10, 8'h00, 8'h01));
    vecs.push_back(mk(0, 0, 0, 0, 8'h00, 0,   0, 1, 1, 8'h2D, 8'h01, 8'h02));

    foreach (vecs[i]) begin
      rst = vecs[i].rst; en = vecs[i].en; halt = vecs[i].halt;
      redirect = vecs[i].redir; redirect_addr = vecs[i].raddr; ir_ready = vecs[i].rdy;
      step();
      chk_all($sformatf("vec%0d", i), vecs[i].e_rd, vecs[i].e_busy, vecs[i].e_valid,
              vecs[i].e_ir, vecs[i].e_irpc, vecs[i].e_pc);
    end

    // Redirect in HOLD with ready: transfer counted, pc reloaded
    en = 1'b1; cnt0 = xfer_cnt;
    redirect = 1'b1; redirect_addr = 8'h80; ir_ready = 1'b1;
    step();
    chk_all("redir_hold", 1, 1, 0, 8'h2D, 8'h01, 8'h80);
    chk("redir_hold.xfer", xfer_cnt, cnt0 + 1);
    redirect = 1'b0;
    step();
    step();
    chk_all("after_redir", 0, 1, 1, 8'h77, 8'h80, 8'h81);

    // Redirect in WAIT: returning 0xAA is dropped
    step();
    chk_all("fetch81", 1, 1, 0, 8'h77, 8'h80, 8'h81);
    step();
    redirect = 1'b1; redirect_addr = 8'h40;
    step();
    chk_all("redir_wait", 1, 1, 0, 8'h77, 8'h80, 8'h40);
    redirect = 1'b0;
    step();
    step();
    chk_all("after_wait_redir", 0, 1, 1, 8'h3C, 8'h40, 8'h41);

    // PC wrap at 0xFF
    redirect = 1'b1; redirect_addr = 8'hFF;
    step();
    redirect = 1'b0;
    step();
    step();
    chk_all("wrap", 0, 1, 1, 8'h99, 8'hFF, 8'h00);

    // halt raised in FETCH: fetch completes, then IDLE with pc held
    step();
    chk_all("fetch0", 1, 1, 0, 8'h99, 8'hFF, 8'h00);
    halt = 1'b1;
    step();
    step();
    chk_all("halt_hold", 0, 1, 1, 8'h10, 8'h00, 8'h01);
    step();
    chk_all("halt_idle", 0, 0, 0, 8'h10, 8'h00, 8'h01);
    step();
    chk_all("halt_idle2", 0, 0, 0, 8'h10, 8'h00, 8'h01);

    // Redirect to the current pc is a plain refetch
    halt = 1'b0; redirect = 1'b1; redirect_addr = 8'h01;
    step();
    chk_all("same_pc", 1, 1, 0, 8'h10, 8'h00, 8'h01);
    redirect = 1'b0; ir_ready = 1'b0;
    step();
    step();
    chk_all("same_pc_hold", 0, 1, 1, 8'h2D, 8'h01, 8'h02);

    // Reset while holding a valid instruction
    rst = 1'b1;
    step();
    chk_all("rst_hold", 0, 0, 0, 8'h00, 8'h00, 8'h00);
    rst = 1'b0; en = 1'b0;
    step();
    chk_all("rst_idle", 0, 0, 0, 8'h00, 8'h00, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
